uart_rx_frame: RTL and testbench

UART_RX_FRAME -- requirements
Module: uart_rx_frame

---
 rtl/uart_rx_frame.sv | 148 ++++++++++++++
 tb/tb_uart_rx_frame.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rs232_rx, requests bit-centre strobes from an
// external baud generator and assembles 8N1 frames; define UART_RX_PARITY_EN for 8E1.
module uart_rx_frame #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rs232_rx,
    input  logic       clk_bps,
    output logic       bps_start,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

`ifdef UART_RX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_prev;
    logic                   rx_cur;
    logic                   rx_fall;

    logic [2:0] state;
    logic [2:0] bit_idx;
    logic [7:0] shift;
`ifdef UART_RX_PARITY_EN
    logic       par_err;
`endif

    // Synchroniser chain and edge-detect flop; resetting to 1 matches an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            rx_prev <= 1'b1;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rs232_rx};
            rx_prev <= rx_cur;
        end
    end

    assign rx_cur  = sync_q[SYNC_STAGES-1];
    assign rx_fall = rx_prev & ~rx_cur;

    // Frame FSM; every sample is taken from the synchronised line on a clk_bps strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            bps_start    <= 1'b0;
            bit_idx      <= 3'd0;
            shift        <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err       <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_fall) begin
                        state     <= START;
                        bps_start <= 1'b1;
                    end
                end
                START: begin
                    if (clk_bps) begin
                        if (rx_cur) begin
                            state     <= IDLE;
                            bps_start <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            par_err <= 1'b0;
`endif
                        end
                    end
                end
                DATA: begin
                    if (clk_bps) begin
                        shift <= {rx_cur, shift[7:1]};
                        // Exit on index 7 so the 3-bit counter never wraps.
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_bps) begin
                        par_err <= (rx_cur != even_parity(shift));
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (clk_bps) begin
                        if (rx_cur) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            rx_parity_err <= par_err;
`endif
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                        state     <= IDLE;
                        bps_start <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    bps_start <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: serial driver, baud generator model and a queue of
// expected frame outcomes compared against the DUT pulses every clock.
`timescale 1ns/1ps
module tb_uart_rx_frame;

    localparam int BIT_CLK = 218;
    localparam int HALF    = 109;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef struct {
        logic       v;
        logic       fe;
        logic       pe;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_parity_err;

    int         bps_cnt;
    int         n_checks = 0;
    int         n_fail = 0;
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    logic [7:0] model_data = 8'h00;
    ev_t        exp_q[$];
    ev_t        cur_ev;

    always #20 clk = ~clk;

    uart_rx_frame #(.SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs232_rx      (rs232_rx),
        .clk_bps       (clk_bps),
        .bps_start     (bps_start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err)
    );

    // Baud generator: strobe at the centre of each 218-clk bit while requested.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)          bps_cnt <= 0;
        else if (!bps_start) bps_cnt <= 0;
        else                 bps_cnt <= (bps_cnt == BIT_CLK - 1) ? 0 : bps_cnt + 1;
    end
    assign clk_bps = bps_start && (bps_cnt == HALF);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Every output pulse must match the oldest expected frame outcome.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid)      valid_cnt++;
            if (rx_frame_err)  ferr_cnt++;
            if (rx_parity_err) perr_cnt++;
            if (rx_valid || rx_frame_err || rx_parity_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 32'd0);
                end else begin
                    cur_ev = exp_q.pop_front();
                    check("pulse_v_fe_pe", {29'd0, rx_valid, rx_frame_err, rx_parity_err},
                          {29'd0, cur_ev.v, cur_ev.fe, cur_ev.pe});
                    if (cur_ev.v) model_data = cur_ev.d;
                end
            end
            check("rx_data", {24'd0, rx_data}, {24'd0, model_data});
        end
    end

    task automatic idle(input int n);
        rs232_rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        rs232_rx = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_bps_start", {31'd0, bps_start}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_pulses", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 32'd0);
        model_data = 8'h00;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // abort_at >= 0 pulses reset in the middle of that data bit and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input int abort_at);
        ev_t e;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abort_at) begin
                rs232_rx = d[i];
                repeat (HALF) @(posedge clk);
                #1;
                do_reset();
                rs232_rx = 1'b1;
                return;
            end
            bit_out(d[i]);
        end
        if (PAR_EN) bit_out(par_b);
        e.v  = stop_b;
        e.fe = ~stop_b;
        e.pe = stop_b & PAR_EN & (par_b != ^d);
        e.d  = d;
        exp_q.push_back(e);
        bit_out(stop_b);
    endtask

    int         v0, f0, p0;
    logic [7:0] rd;
    logic       rstop, rpar, prev_low;

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check("reset_bps_start", {31'd0, bps_start}, 32'd0);
        check("reset_rx_data", {24'd0, rx_data}, 32'h00);
        check("reset_pulses", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 32'd0);
        rst_n = 1'b1;
        idle(20);

        // Good frame 0xA5
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, ^8'hA5, -1);
        idle(50);
        check("a5_rx_data", {24'd0, rx_data}, 32'hA5);
        check("a5_valid_cnt", valid_cnt - v0, 32'd1);
        check("a5_ferr_cnt", ferr_cnt - f0, 32'd0);
        check("a5_bps_start", {31'd0, bps_start}, 32'd0);

        // Framing error on 0x00
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h00, 1'b0, 1'b0, -1);
        idle(50);
        check("ferr_cnt", ferr_cnt - f0, 32'd1);
        check("ferr_valid_cnt", valid_cnt - v0, 32'd0);
        check("ferr_rx_data", {24'd0, rx_data}, 32'hA5);

        // 50-clk low glitch gives a false start
        v0 = valid_cnt; f0 = ferr_cnt;
        rs232_rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        idle(10);
        check("glitch_bps_high", {31'd0, bps_start}, 32'd1);
        idle(150);
        check("glitch_bps_low", {31'd0, bps_start}, 32'd0);
        check("glitch_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);

        // Reset during data bit 4, then a complete 0x3C
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1, ^8'h3C, 4);
        idle(300);
        check("abort_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 32'd0);
        send_frame(8'h3C, 1'b1, ^8'h3C, -1);
        idle(50);
        check("3c_rx_data", {24'd0, rx_data}, 32'h3C);
        check("3c_valid_cnt", valid_cnt - v0, 32'd1);

        // Back-to-back 0x55, 0xAA
        v0 = valid_cnt;
        send_frame(8'h55, 1'b1, ^8'h55, -1);
        send_frame(8'hAA, 1'b1, ^8'hAA, -1);
        idle(50);
        check("b2b_valid_cnt", valid_cnt - v0, 32'd2);
        check("b2b_rx_data", {24'd0, rx_data}, 32'hAA);
        check("b2b_queue_empty", exp_q.size(), 32'd0);

`ifdef UART_RX_PARITY_EN
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(50);
        check("par_bad_valid", valid_cnt - v0, 32'd1);
        check("par_bad_perr", perr_cnt - p0, 32'd1);
        check("par_bad_data", {24'd0, rx_data}, 32'h07);
        v0 = valid_cnt; p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(50);
        check("par_ok_valid", valid_cnt - v0, 32'd1);
        check("par_ok_perr", perr_cnt - p0, 32'd0);
`else
        p0 = perr_cnt;
`endif

        // Randomised traffic with glitches, bad stop bits and gaps
        prev_low = 1'b0;
        for (int n = 0; n < 16; n++) begin
            rd    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rpar  = ($urandom_range(0, 3) == 0) ? ~(^rd) : ^rd;
            if ($urandom_range(0, 5) == 0) begin
                rs232_rx = 1'b0;
                repeat ($urandom_range(1, 80)) @(posedge clk);
                #1;
                idle(300);
                prev_low = 1'b0;
            end
            if (prev_low) idle(30 + $urandom_range(0, 200));
            else          idle($urandom_range(0, 300));
            send_frame(rd, rstop, rpar, -1);
            prev_low = ~rstop;
        end
        idle(300);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_bps_start", {31'd0, bps_start}, 32'd0);
        if (!PAR_EN) check("no_parity_pulses", perr_cnt - p0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
